// File: rtl/conv_pkg.sv
// Shared types, configuration map and helpers for the int8 convolution datapath
// (window buffer, MAC/requant, pooling and later PE stages).
package conv_pkg;

    localparam int PIX_W  = 8;
    localparam int PROD_W = 16;

    localparam logic [3:0] CFG_W0    = 4'd0;
    localparam logic [3:0] CFG_BIAS  = 4'd9;
    localparam logic [3:0] CFG_SHIFT = 4'd10;
    localparam logic [3:0] CFG_RELU  = 4'd11;
    localparam logic [3:0] CFG_LAST  = 4'd11;

    localparam int Q_MAX = 127;
    localparam int Q_MIN = -128;

    typedef logic signed [PIX_W-1:0]  pix_t;
    typedef logic signed [PROD_W-1:0] prod_t;

    // Full-precision int8 x int8 product; both operands widened before the multiply.
    function automatic prod_t mul_pix(input pix_t a, input pix_t b);
        prod_t a_s;
        prod_t b_s;
        a_s = {{(PROD_W-PIX_W){a[PIX_W-1]}}, a};
        b_s = {{(PROD_W-PIX_W){b[PIX_W-1]}}, b};
        return a_s * b_s;
    endfunction

endpackage

// File: rtl/conv3x3_mac_requant_if.sv
// Window, configuration and result signals of the 3x3 MAC/requant stage.
interface conv3x3_mac_requant_if;
    import conv_pkg::*;

    logic        valid_in;
    pix_t        data_in0;
    pix_t        data_in1;
    pix_t        data_in2;
    pix_t        data_in3;
    pix_t        data_in4;
    pix_t        data_in5;
    pix_t        data_in6;
    pix_t        data_in7;
    pix_t        data_in8;
    logic        cfg_wr_en;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        cfg_err;
    logic        busy;
    pix_t        data_out;
    logic        valid_out;

    modport master (
        output valid_in, data_in0, data_in1, data_in2, data_in3, data_in4,
               data_in5, data_in6, data_in7, data_in8,
               cfg_wr_en, cfg_addr, cfg_wdata,
        input  cfg_err, busy, data_out, valid_out
    );

    modport slave (
        input  valid_in, data_in0, data_in1, data_in2, data_in3, data_in4,
               data_in5, data_in6, data_in7, data_in8,
               cfg_wr_en, cfg_addr, cfg_wdata,
        output cfg_err, busy, data_out, valid_out
    );

endinterface

// File: rtl/requant_sat.sv
// Combinational requantizer: round-half-up arithmetic right shift, optional ReLU,
// saturation to int8. Shared with the 1x1 conv and fully-connected blocks.
module requant_sat
    import conv_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic [3:0]              shift,
    input  logic                    relu_en,
    output pix_t                    q
);

    localparam logic signed [ACC_W:0] ONE_E = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0] MAX_E = (ACC_W+1)'(Q_MAX);
    localparam logic signed [ACC_W:0] MIN_E = (ACC_W+1)'(Q_MIN);

    logic signed [ACC_W:0] ext_s;
    logic signed [ACC_W:0] rnd_s;
    logic signed [ACC_W:0] t_s;
    logic signed [ACC_W:0] relu_s;

    // One guard bit keeps the rounding add from wrapping at any accumulator value.
    always_comb begin
        ext_s  = {acc[ACC_W-1], acc};
        rnd_s  = '0;
        t_s    = ext_s;
        relu_s = ext_s;
        q      = '0;

        if (shift == 4'd0) begin
            t_s = ext_s;
        end else begin
            rnd_s = ONE_E << (shift - 4'd1);
            t_s   = (ext_s + rnd_s) >>> shift;
        end

        if (relu_en && t_s[ACC_W]) begin
            relu_s = '0;
        end else begin
            relu_s = t_s;
        end

        if (relu_s > MAX_E) begin
            q = PIX_W'(Q_MAX);
        end else if (relu_s < MIN_E) begin
            q = PIX_W'(Q_MIN);
        end else begin
            q = relu_s[PIX_W-1:0];
        end
    end

endmodule

// File: rtl/conv3x3_mac_requant.sv
// 3x3 int8 convolution PE: products, row sums, bias accumulate and requantize in a
// fixed 4-stage pipeline, with a small write-only coefficient register file.
module conv3x3_mac_requant
    import conv_pkg::*;
#(
    parameter int ACC_W  = 24,
    parameter int BIAS_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    conv3x3_mac_requant_if.slave   bus
);

    pix_t                     pix_s [9];
    pix_t                     w_r [9];
    logic signed [BIAS_W-1:0] bias_r;
    logic [3:0]               shift_r;
    logic                     relu_r;

    prod_t                    prod_r [9];
    logic signed [ACC_W-1:0]  row_s [3];
    logic signed [ACC_W-1:0]  row_r [3];
    logic signed [ACC_W-1:0]  acc_s;
    logic signed [ACC_W-1:0]  acc_r;
    logic                     v1_r;
    logic                     v2_r;
    logic                     v3_r;
    logic                     valid_out_r;
    pix_t                     data_out_r;
    pix_t                     q_s;
    logic                     cfg_err_r;
    logic                     busy_s;
    logic                     cfg_ok_s;

    function automatic logic signed [ACC_W-1:0] sx_prod(input prod_t p);
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    assign pix_s[0] = bus.data_in0;
    assign pix_s[1] = bus.data_in1;
    assign pix_s[2] = bus.data_in2;
    assign pix_s[3] = bus.data_in3;
    assign pix_s[4] = bus.data_in4;
    assign pix_s[5] = bus.data_in5;
    assign pix_s[6] = bus.data_in6;
    assign pix_s[7] = bus.data_in7;
    assign pix_s[8] = bus.data_in8;

    // Writes are refused while anything is in flight so every window sees one coefficient set.
    assign busy_s   = bus.valid_in | v1_r | v2_r | v3_r;
    assign cfg_ok_s = bus.cfg_wr_en & ~busy_s & (bus.cfg_addr <= CFG_LAST);

    // Configuration registers and the registered reject pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                w_r[k] <= '0;
            end
            bias_r    <= '0;
            shift_r   <= 4'd0;
            relu_r    <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= bus.cfg_wr_en & ~cfg_ok_s;
            if (cfg_ok_s) begin
                for (int k = 0; k < 9; k++) begin
                    if (bus.cfg_addr == CFG_W0 + 4'(k)) begin
                        w_r[k] <= bus.cfg_wdata[PIX_W-1:0];
                    end
                end
                case (bus.cfg_addr)
                    CFG_BIAS:  bias_r  <= bus.cfg_wdata[BIAS_W-1:0];
                    CFG_SHIFT: shift_r <= bus.cfg_wdata[3:0];
                    CFG_RELU:  relu_r  <= bus.cfg_wdata[0];
                    default:   ;
                endcase
            end
        end
    end

    // Row sums and final accumulate; ACC_W >= 21 leaves headroom for 9 products plus bias.
    always_comb begin
        for (int j = 0; j < 3; j++) begin
            row_s[j] = sx_prod(prod_r[3*j]) + sx_prod(prod_r[3*j+1]) + sx_prod(prod_r[3*j+2]);
        end
        acc_s = row_r[0] + row_r[1] + row_r[2]
              + {{(ACC_W-BIAS_W){bias_r[BIAS_W-1]}}, bias_r};
    end

    requant_sat #(
        .ACC_W   (ACC_W)
    ) u_requant (
        .acc     (acc_r),
        .shift   (shift_r),
        .relu_en (relu_r),
        .q       (q_s)
    );

    // Valids advance every cycle; each data stage loads only when its incoming valid is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r        <= 1'b0;
            v2_r        <= 1'b0;
            v3_r        <= 1'b0;
            valid_out_r <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                prod_r[k] <= '0;
            end
            for (int j = 0; j < 3; j++) begin
                row_r[j] <= '0;
            end
            acc_r      <= '0;
            data_out_r <= '0;
        end else begin
            v1_r        <= bus.valid_in;
            v2_r        <= v1_r;
            v3_r        <= v2_r;
            valid_out_r <= v3_r;
            if (bus.valid_in) begin
                for (int k = 0; k < 9; k++) begin
                    prod_r[k] <= mul_pix(pix_s[k], w_r[k]);
                end
            end
            if (v1_r) begin
                for (int j = 0; j < 3; j++) begin
                    row_r[j] <= row_s[j];
                end
            end
            if (v2_r) begin
                acc_r <= acc_s;
            end
            if (v3_r) begin
                data_out_r <= q_s;
            end
        end
    end

    assign bus.busy      = busy_s;
    assign bus.cfg_err   = cfg_err_r;
    assign bus.data_out  = data_out_r;
    assign bus.valid_out = valid_out_r;

endmodule

// File: tb/tb_conv3x3_mac_requant.sv
// Directed bench for conv3x3_mac_requant: a vector table of configurations/windows with
// hand-computed results, plus sequences for latency, reset and write rejection.
module tb_conv3x3_mac_requant;
    import conv_pkg::*;

    typedef logic [8:0][7:0] win_t;

    typedef struct packed {
        win_t        w;
        logic [15:0] bias;
        logic [3:0]  shift;
        logic        relu;
        win_t        pix;
        logic [7:0]  exp;
    } vec_t;

    localparam int NVEC = 13;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    conv3x3_mac_requant_if bus ();

    conv3x3_mac_requant #(
        .ACC_W  (24),
        .BIAS_W (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic win_t fill(input logic [7:0] v);
        win_t r;
        for (int k = 0; k < 9; k++) r[k] = v;
        return r;
    endfunction

    function automatic win_t ramp();
        win_t r;
        for (int k = 0; k < 9; k++) r[k] = 8'(k + 1);
        return r;
    endfunction

    function automatic win_t center(input logic [7:0] v, input logic [7:0] others);
        win_t r;
        r    = fill(others);
        r[4] = v;
        return r;
    endfunction

    function automatic vec_t mk(input win_t w, input logic [15:0] b, input logic [3:0] s,
                                input logic r, input win_t p, input logic [7:0] e);
        vec_t v;
        v.w = w; v.bias = b; v.shift = s; v.relu = r; v.pix = p; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic drive_pix(input win_t p);
        bus.data_in0 = p[0]; bus.data_in1 = p[1]; bus.data_in2 = p[2];
        bus.data_in3 = p[3]; bus.data_in4 = p[4]; bus.data_in5 = p[5];
        bus.data_in6 = p[6]; bus.data_in7 = p[7]; bus.data_in8 = p[8];
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
        bus.cfg_wr_en = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_wdata = d;
        @(negedge clk);
        bus.cfg_wr_en = 1'b0;
    endtask

    task automatic load_cfg(input win_t w, input logic [15:0] b, input logic [3:0] s,
                            input logic r);
        for (int k = 0; k < 9; k++) cfg_write(4'(k), {8'h00, w[k]});
        cfg_write(4'd9, b);
        cfg_write(4'd10, {12'h000, s});
        cfg_write(4'd11, {15'h0000, r});
    endtask

    // One window in, result expected on the fourth following sample point, then idle.
    task automatic run_window(input win_t p, input logic signed [7:0] exp, input string name);
        bus.valid_in = 1'b1;
        drive_pix(p);
        @(negedge clk);
        bus.valid_in = 1'b0;
        repeat (3) @(negedge clk);
        check({name, "_valid"}, 32'(bus.valid_out), 32'sd1);
        check({name, "_data"}, $signed(bus.data_out), exp);
        @(negedge clk);
        check({name, "_valid_drop"}, 32'(bus.valid_out), 32'sd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;

        vecs[0]  = mk(fill(8'h01), 16'h0000, 4'd0, 1'b0, ramp(), 8'd45);
        vecs[1]  = mk({8'h05, 8'hFC, 8'h04, 8'hFD, 8'h03, 8'hFE, 8'h02, 8'hFF, 8'h01},
                      16'h0000, 4'd0, 1'b0, ramp(), 8'd35);
        vecs[2]  = mk(fill(8'h7F), 16'h0000, 4'd0, 1'b0, fill(8'h7F), 8'h7F);
        vecs[3]  = mk(fill(8'h7F), 16'h0000, 4'd0, 1'b0, fill(8'h80), 8'h80);
        vecs[4]  = mk(center(8'h01, 8'h00), 16'h0000, 4'd1, 1'b0, center(8'h05, 8'h32), 8'd3);
        vecs[5]  = mk(center(8'h01, 8'h00), 16'h0000, 4'd1, 1'b0, center(8'hFB, 8'h32), 8'hFE);
        vecs[6]  = mk(center(8'h01, 8'h00), 16'h0000, 4'd1, 1'b0, center(8'h04, 8'h32), 8'd2);
        vecs[7]  = mk(center(8'h01, 8'h00), 16'h0000, 4'd15, 1'b0, center(8'h7F, 8'h32), 8'd0);
        vecs[8]  = mk(center(8'h01, 8'h00), 16'h0000, 4'd2, 1'b0, center(8'hFA, 8'h32), 8'hFF);
        vecs[9]  = mk(fill(8'h01), 16'd30, 4'd3, 1'b0, fill(8'h0A), 8'd15);
        vecs[10] = mk(fill(8'h01), 16'hFF9C, 4'd0, 1'b0, fill(8'h01), 8'hA5);
        vecs[11] = mk(fill(8'h01), 16'hFF9C, 4'd0, 1'b1, fill(8'h01), 8'd0);
        vecs[12] = mk(fill(8'h01), 16'd200, 4'd0, 1'b1, fill(8'h01), 8'h7F);

        rst           = 1'b1;
        bus.valid_in  = 1'b0;
        bus.cfg_wr_en = 1'b0;
        bus.cfg_addr  = 4'd0;
        bus.cfg_wdata = 16'h0000;
        drive_pix('0);
        repeat (3) @(negedge clk);
        check("rst_data_out", $signed(bus.data_out), 32'sd0);
        check("rst_valid_out", 32'(bus.valid_out), 32'sd0);
        check("rst_cfg_err", 32'(bus.cfg_err), 32'sd0);
        check("rst_busy", 32'(bus.busy), 32'sd0);
        rst = 1'b0;
        @(negedge clk);

        // Default weights: result 0, valid exactly four samples after the window.
        bus.valid_in = 1'b1;
        drive_pix(fill(8'h01));
        #1 check("busy_on_valid_in", 32'(bus.busy), 32'sd1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            bus.valid_in = 1'b0;
            check($sformatf("latency_valid_t%0d", i), 32'(bus.valid_out), (i == 4) ? 32'sd1 : 32'sd0);
        end
        check("default_weights_data", $signed(bus.data_out), 32'sd0);
        @(negedge clk);
        check("default_valid_drop", 32'(bus.valid_out), 32'sd0);
        check("busy_idle", 32'(bus.busy), 32'sd0);

        // Reset mid-stream drops the window and clears coefficients.
        load_cfg(fill(8'h01), 16'h0000, 4'd0, 1'b0);
        bus.valid_in = 1'b1;
        drive_pix(fill(8'h01));
        @(negedge clk);
        bus.valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", 32'(bus.busy), 32'sd0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.valid_out) seen++;
        end
        check("rst_mid_no_valid", seen, 32'sd0);
        run_window(fill(8'h01), 8'sd0, "rst_cleared_weights");

        // Three back-to-back windows.
        load_cfg(fill(8'h01), 16'h0000, 4'd0, 1'b0);
        bus.valid_in = 1'b1;
        drive_pix(ramp());
        @(negedge clk);
        drive_pix(fill(8'h02));
        @(negedge clk);
        drive_pix(fill(8'hFF));
        @(negedge clk);
        bus.valid_in = 1'b0;
        @(negedge clk);
        check("b2b_0_data", $signed(bus.data_out), 32'sd45);
        check("b2b_0_valid", 32'(bus.valid_out), 32'sd1);
        @(negedge clk);
        check("b2b_1_data", $signed(bus.data_out), 32'sd18);
        check("b2b_1_valid", 32'(bus.valid_out), 32'sd1);
        @(negedge clk);
        check("b2b_2_data", $signed(bus.data_out), -32'sd9);
        check("b2b_2_valid", 32'(bus.valid_out), 32'sd1);
        @(negedge clk);
        check("b2b_end_valid", 32'(bus.valid_out), 32'sd0);

        // Writes alongside valid_in and while the pipeline drains are refused.
        bus.valid_in  = 1'b1;
        drive_pix(fill(8'h01));
        bus.cfg_wr_en = 1'b1;
        bus.cfg_addr  = 4'd0;
        bus.cfg_wdata = 16'h0005;
        @(negedge clk);
        bus.valid_in = 1'b0;
        check("rej_same_cycle_err", 32'(bus.cfg_err), 32'sd1);
        @(negedge clk);
        bus.cfg_wr_en = 1'b0;
        check("rej_busy_err", 32'(bus.cfg_err), 32'sd1);
        @(negedge clk);
        check("rej_err_drop", 32'(bus.cfg_err), 32'sd0);
        @(negedge clk);
        check("rej_inflight_valid", 32'(bus.valid_out), 32'sd1);
        check("rej_inflight_data", $signed(bus.data_out), 32'sd9);
        @(negedge clk);
        run_window(fill(8'h01), 8'sd9, "rej_w0_kept");

        // Out-of-range addresses pulse cfg_err and leave state alone.
        cfg_write(4'd12, 16'h0005);
        check("addr12_err", 32'(bus.cfg_err), 32'sd1);
        @(negedge clk);
        check("addr12_err_drop", 32'(bus.cfg_err), 32'sd0);
        cfg_write(4'd15, 16'hFFFF);
        check("addr15_err", 32'(bus.cfg_err), 32'sd1);
        cfg_write(4'd11, 16'h0000);
        check("good_write_no_err", 32'(bus.cfg_err), 32'sd0);
        run_window(fill(8'h01), 8'sd9, "addr12_no_change");

        for (int i = 0; i < NVEC; i++) begin
            load_cfg(vecs[i].w, vecs[i].bias, vecs[i].shift, vecs[i].relu);
            run_window(vecs[i].pix, $signed(vecs[i].exp), $sformatf("vec%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
